interrupt_example_cpu_dct_capture_ctrl: RTL

INTERRUPT_EXAMPLE_CPU_DCT_CAPTURE_CTRL -- requirements
Module: interrupt_example_cpu_dct_capture_ctrl

---
 rtl/interrupt_example_cpu_dct_capture_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/interrupt_example_cpu_dct_capture_ctrl.sv
// Trace-atom capture controller: packs 2-bit atoms into 30-bit frames and hands them
// to a ready/valid consumer, with backpressure drop accounting and an end-of-test drain.
module interrupt_example_cpu_dct_capture_ctrl #(
  parameter int MAX_ATOMS = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, ENDED} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

  state_t      state;
  logic        flush_pend;

  logic        slot_free, take, flush_req, full;
  logic        handoff, drop, drain_done, nxt_pend;
  logic [29:0] hand_buf, nxt_buf;
  logic [3:0]  hand_cnt, nxt_cnt;

  always_comb begin
    slot_free  = !frame_valid || frame_ready;
    take       = (state == CAPTURE) && atom_valid;
    flush_req  = (state == DRAIN) || ((state != ENDED) && (flush || flush_pend));
    full       = (dct_count == MAX_CNT);
    handoff    = 1'b0;
    drop       = 1'b0;
    hand_buf   = dct_buffer;
    hand_cnt   = dct_count;
    nxt_buf    = dct_buffer;
    nxt_cnt    = dct_count;
    nxt_pend   = flush_pend;
    if (state == ENDED) begin
      nxt_pend = 1'b0;
    end else if (full) begin
      // A blocked buffer empties first; an atom arriving that cycle lands in the empty buffer.
      if (slot_free) begin
        handoff  = 1'b1;
        nxt_buf  = take ? {28'd0, atom} : 30'd0;
        nxt_cnt  = take ? 4'd1 : 4'd0;
        nxt_pend = 1'b0;
      end else begin
        drop     = take;
        nxt_pend = flush_pend || flush;
      end
    end else begin
      if (take) begin
        nxt_buf = {dct_buffer[27:0], atom};
        nxt_cnt = dct_count + 4'd1;
      end
      if (nxt_cnt == MAX_CNT || (flush_req && nxt_cnt != 4'd0)) begin
        if (slot_free) begin
          handoff  = 1'b1;
          hand_buf = nxt_buf;
          hand_cnt = nxt_cnt;
          nxt_buf  = 30'd0;
          nxt_cnt  = 4'd0;
          nxt_pend = 1'b0;
        end else begin
          nxt_pend = flush_req && (nxt_cnt != 4'd0);
        end
      end else begin
        nxt_pend = 1'b0;
      end
    end
    // Finish drain on the edge where the last frame is taken, not one cycle later.
    drain_done = (state == DRAIN) && slot_free && (dct_count == 4'd0) && !handoff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      flush_pend     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      frame_valid    <= 1'b0;
      frame_data     <= '0;
      frame_count    <= '0;
      overflow       <= 1'b0;
      drop_count     <= '0;
      test_has_ended <= 1'b0;
    end else begin
      dct_buffer <= nxt_buf;
      dct_count  <= nxt_cnt;
      flush_pend <= nxt_pend;
      if (handoff) begin
        frame_valid <= 1'b1;
        frame_data  <= hand_buf;
        frame_count <= hand_cnt;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (test_ending)  state <= DRAIN;
          else if (enable)  state <= CAPTURE;
        end
        CAPTURE: begin
          if (test_ending)  state <= DRAIN;
          else if (!enable) state <= IDLE;
        end
        DRAIN: begin
          if (drain_done) begin
            state          <= ENDED;
            test_has_ended <= 1'b1;
          end
        end
        default: test_has_ended <= 1'b1;
      endcase
    end
  end

endmodule
